// File: rtl/dot_accumulator_pkg.sv
// Shared matrix-datapath definitions: accumulator FSM states, default widths
// and the multiplier-to-accumulator alignment helper.
package mat_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int ACC_WIDTH_DEF = 24;

  // Products trail their operands by the multiplier core latency plus its
  // input and output registers.
  function automatic int calc_align(input int mult_latency);
    return mult_latency + 2;
  endfunction

endpackage

// File: rtl/dot_accumulator_if.sv
// Product stream into the dot-product accumulator and its result outputs.
interface dot_accumulator_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int DOT_LEN   = 16
);
  localparam int CW = $clog2(DOT_LEN + 1);

  logic                 op_valid;
  logic                 op_last;
  logic [2*WIDTH-1:0]   prod;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 acc_valid;
  logic [CW-1:0]        term_cnt;
  logic                 err_len;

  modport master (
    output op_valid, op_last, prod,
    input  acc_out, acc_valid, term_cnt, err_len
  );

  modport slave (
    input  op_valid, op_last, prod,
    output acc_out, acc_valid, term_cnt, err_len
  );
endinterface

// File: rtl/dot_accumulator_flag_delay.sv
// Fixed-depth shift register with synchronous clear; carries operand flags
// alongside the multiplier pipeline.
module flag_delay #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/dot_accumulator.sv
// Sums the aligned product stream into one dot product per op_last.
// Optional build macro ACC_SAT_EN: saturating adds, saturation flagged on err_len.
module dot_accumulator
  import mat_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MULT_LATENCY = 3,
  parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
  parameter int DOT_LEN      = 16
) (
  input logic             clk,
  input logic             rst,
  dot_accumulator_if.slave bus
);

  localparam int ALIGN = calc_align(MULT_LATENCY);
  localparam int CW    = $clog2(DOT_LEN + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DOT_LEN);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DOT_LEN + 1);

  typedef logic [ACC_WIDTH-1:0] acc_t;

`ifdef ACC_SAT_EN
  // Top bit of the result reports that the add clipped.
  function automatic logic [ACC_WIDTH:0] add_acc(input acc_t a, input acc_t b);
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_WIDTH] ? {1'b1, {ACC_WIDTH{1'b1}}} : s;
  endfunction
`else
  function automatic acc_t add_acc(input acc_t a, input acc_t b);
    return a + b;
  endfunction
`endif

  // ---- flag alignment: pv/pl line up with the matching product ----
  logic [1:0] flags;
  logic       pv, pl;

  flag_delay #(
    .DEPTH (ALIGN),
    .WIDTH (2)
  ) u_flag_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({bus.op_valid, bus.op_valid & bus.op_last}),
    .dout (flags)
  );

  assign pv = flags[1];
  assign pl = flags[0];

  state_t        state, state_n;
  acc_t          acc, acc_n, acc_out, acc_out_n, base, sum;
  logic          acc_valid, acc_valid_n, err_len, err_len_n, bad_final;
  logic [CW-1:0] term_cnt, term_cnt_n, cnt_final;
`ifdef ACC_SAT_EN
  logic               sat_seen, sat_seen_n, sat_final;
  logic [ACC_WIDTH:0] add_res;
`endif

  // ---- accumulate: IDLE starts a fresh sum from zero ----
  always_comb begin
    base      = (state == ACCUM) ? acc : '0;
    cnt_final = (state == IDLE)     ? CW'(1)   :
                (term_cnt == CNT_MAX) ? term_cnt : term_cnt + CW'(1);
`ifdef ACC_SAT_EN
    add_res   = add_acc(base, ACC_WIDTH'(bus.prod));
    sum       = add_res[ACC_WIDTH-1:0];
    sat_final = add_res[ACC_WIDTH] | ((state == ACCUM) & sat_seen);
    bad_final = (cnt_final != CNT_FULL) | sat_final;
`else
    sum       = add_acc(base, ACC_WIDTH'(bus.prod));
    bad_final = (cnt_final != CNT_FULL);
`endif
  end

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    acc_out_n   = acc_out;
    acc_valid_n = 1'b0;
    err_len_n   = 1'b0;
    term_cnt_n  = term_cnt;
`ifdef ACC_SAT_EN
    sat_seen_n  = sat_seen;
`endif
    if (pv) begin
      if (pl) begin
        acc_out_n   = sum;
        acc_valid_n = 1'b1;
        err_len_n   = bad_final;
        term_cnt_n  = '0;
        state_n     = IDLE;
`ifdef ACC_SAT_EN
        sat_seen_n  = 1'b0;
`endif
      end else begin
        acc_n       = sum;
        term_cnt_n  = cnt_final;
        state_n     = ACCUM;
`ifdef ACC_SAT_EN
        sat_seen_n  = sat_final;
`endif
      end
    end
  end

  // ---- result register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      err_len   <= 1'b0;
      term_cnt  <= '0;
`ifdef ACC_SAT_EN
      sat_seen  <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      acc_out   <= acc_out_n;
      acc_valid <= acc_valid_n;
      err_len   <= err_len_n;
      term_cnt  <= term_cnt_n;
`ifdef ACC_SAT_EN
      sat_seen  <= sat_seen_n;
`endif
    end
  end

  assign bus.acc_out   = acc_out;
  assign bus.acc_valid = acc_valid;
  assign bus.err_len   = err_len;
  assign bus.term_cnt  = term_cnt;

endmodule

// File: tb/tb_dot_accumulator.sv
// Bench for dot_accumulator: 24-bit and 20-bit accumulators fed the same
// operand stream through a behavioural multiplier, checked against a term-sum model.
module tb_dot_accumulator;

  localparam int WIDTH        = 8;
  localparam int MULT_LATENCY = 3;
  localparam int DOT_LEN      = 16;
  localparam int ALIGN        = MULT_LATENCY + 2;
  localparam int NC           = 4096;
`ifdef ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  dot_accumulator_if #(.WIDTH(WIDTH), .ACC_WIDTH(24), .DOT_LEN(DOT_LEN)) if24 ();
  dot_accumulator_if #(.WIDTH(WIDTH), .ACC_WIDTH(20), .DOT_LEN(DOT_LEN)) if20 ();

  dot_accumulator #(.WIDTH(WIDTH), .MULT_LATENCY(MULT_LATENCY), .ACC_WIDTH(24),
                    .DOT_LEN(DOT_LEN)) dut24 (.clk(clk), .rst(rst), .bus(if24));
  dot_accumulator #(.WIDTH(WIDTH), .MULT_LATENCY(MULT_LATENCY), .ACC_WIDTH(20),
                    .DOT_LEN(DOT_LEN)) dut20 (.clk(clk), .rst(rst), .bus(if20));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Operand history per cycle; the multiplier model replays products ALIGN later.
  bit              rec_v [NC];
  bit              rec_l [NC];
  longint unsigned rec_p [NC];

  longint unsigned m_sum;
  int              m_cnt;
  logic [23:0]     e_acc24;
  logic [19:0]     e_acc20;
  logic            e_valid, e_err24, e_err20;
  logic [4:0]      e_cnt;
  int              pulses [$];

  function automatic longint unsigned fold(input longint unsigned s, input int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 1;
    if (SAT_EN) return (s > mx) ? mx : s;
    return s & mx;
  endfunction

  function automatic bit over(input longint unsigned s, input int w);
    return SAT_EN && (s > ((64'd1 << w) - 1));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Effect of the clock edge that ends cycle cyc: the term issued ALIGN cycles
  // earlier joins the running dot product; reset drops everything in flight.
  task automatic model_edge(input bit r);
    int k;
    e_valid = 1'b0;
    e_err24 = 1'b0;
    e_err20 = 1'b0;
    if (r) begin
      m_sum   = 0;
      m_cnt   = 0;
      e_acc24 = '0;
      e_acc20 = '0;
      e_cnt   = '0;
      for (int i = 0; i <= cyc; i++) rec_v[i] = 1'b0;
      return;
    end
    k = cyc - ALIGN;
    if (k >= 0 && rec_v[k]) begin
      m_sum += rec_p[k];
      m_cnt++;
      if (rec_l[k]) begin
        e_valid = 1'b1;
        e_acc24 = 24'(fold(m_sum, 24));
        e_acc20 = 20'(fold(m_sum, 20));
        e_err24 = (m_cnt != DOT_LEN) || over(m_sum, 24);
        e_err20 = (m_cnt != DOT_LEN) || over(m_sum, 20);
        pulses.push_back(cyc + 1);
        m_sum = 0;
        m_cnt = 0;
      end
    end
    e_cnt = 5'((m_cnt > DOT_LEN + 1) ? DOT_LEN + 1 : m_cnt);
  endtask

  task automatic check_all();
    chk("acc_valid24", if24.acc_valid, e_valid);
    chk("acc_valid20", if20.acc_valid, e_valid);
    chk("acc_out24",   if24.acc_out,   e_acc24);
    chk("acc_out20",   if20.acc_out,   e_acc20);
    chk("err_len24",   if24.err_len,   e_err24);
    chk("err_len20",   if20.err_len,   e_err20);
    chk("term_cnt24",  if24.term_cnt,  e_cnt);
    chk("term_cnt20",  if20.term_cnt,  e_cnt);
  endtask

  task automatic step(input bit v, input bit l, input int unsigned a,
                      input int unsigned b, input bit r);
    logic [15:0] p;
    logic        l_drv;
    if (cyc >= NC - 1) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NC - 1);
      $fatal(1, "cycle budget exhausted");
    end
    rec_v[cyc] = v & ~r;
    rec_l[cyc] = v & l;
    rec_p[cyc] = longint'(a) * longint'(b);
    if (cyc >= ALIGN && rec_v[cyc-ALIGN]) p = 16'(rec_p[cyc-ALIGN]);
    else p = 16'($urandom);
    l_drv = v ? l : 1'($urandom);
    rst           = r;
    if24.op_valid = v;
    if24.op_last  = l_drv;
    if24.prod     = p;
    if20.op_valid = v;
    if20.op_last  = l_drv;
    if20.prod     = p;
    @(posedge clk);
    model_edge(r);
    cyc++;
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic dot(input int unsigned a, input int unsigned b, input int n);
    for (int i = 0; i < n; i++) step(1'b1, i == n - 1, a, b, 1'b0);
  endtask

  initial begin
    int c0;
    int run;

    // reset
    step(1'b0, 1'b0, 0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    chk("rst_acc_out", if24.acc_out, 0);
    chk("rst_term_cnt", if24.term_cnt, 0);
    idle(3);

    // 1: (i+1)*2 for 16 terms
    pulses.delete();
    c0 = cyc;
    for (int i = 0; i < 16; i++) step(1'b1, i == 15, i + 1, 2, 1'b0);
    idle(ALIGN + 3);
    chk("t1_pulses", pulses.size(), 1);
    chk("t1_latency", (pulses.size() > 0) ? pulses[0] - c0 : -1, 21);
    chk("t1_acc", if24.acc_out, 272);

    // 2/3: 16 then 17 terms of 255*255 (wraps or saturates at 20 bits)
    dot(255, 255, 16);
    idle(ALIGN + 3);
    chk("t2_acc24_16", if24.acc_out, 1040400);
    chk("t2_acc20_16", if20.acc_out, 1040400);
    dot(255, 255, 17);
    idle(ALIGN + 3);
    chk("t2_acc24_17", if24.acc_out, 1105425);
    chk("t2_acc20_17", if20.acc_out, SAT_EN ? 1048575 : 56849);

    // 4: back-to-back dot products with no gap
    pulses.delete();
    dot(3, 4, 16);
    dot(1, 1, 16);
    idle(ALIGN + 3);
    chk("t4_pulses", pulses.size(), 2);
    chk("t4_spacing", (pulses.size() > 1) ? pulses[1] - pulses[0] : -1, 16);
    chk("t4_acc", if24.acc_out, 16);

    // 5: single-term dot product
    dot(7, 9, 1);
    idle(ALIGN + 3);
    chk("t5_acc", if24.acc_out, 63);
    chk("t5_term_cnt", if24.term_cnt, 0);

    // 6: reset part-way through a dot product
    pulses.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1, 1, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    dot(1, 1, 16);
    idle(ALIGN + 3);
    chk("t6_pulses", pulses.size(), 1);
    chk("t6_acc", if24.acc_out, 16);

    // randomized stream with gaps, mixed lengths and rare resets
    run = 0;
    for (int i = 0; i < 600; i++) begin
      bit v, l, r;
      r = ($urandom_range(0, 249) == 0);
      v = !r && ($urandom_range(0, 9) < 7);
      l = v && (($urandom_range(0, 19) == 0) || (run == DOT_LEN - 1) || (run > DOT_LEN + 2));
      if (r) run = 0;
      else if (v) run = l ? 0 : run + 1;
      step(v, l, $urandom_range(0, 255), $urandom_range(0, 255), r);
    end
    idle(ALIGN + 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
